// File: rtl/ntt_pkg.sv
// Shared NTT definitions: default ring geometry, coefficient type and reader states.
package ntt_pkg;

    localparam int unsigned NTT_RING_SIZE  = 256;
    localparam int unsigned NTT_DATA_WIDTH = 32;

    typedef logic [NTT_DATA_WIDTH-1:0] coeff_t;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_e;

endpackage

// File: rtl/ntt_pingpong_bank.sv
// Two-bank coefficient store: dual-word write of a butterfly pair, one combinational read port.
module ntt_pingpong_bank #(
    parameter int unsigned RING_SIZE  = 256,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IDX_WIDTH  = $clog2(RING_SIZE)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic                  wr_bank,
    input  logic [IDX_WIDTH-2:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data_lo,
    input  logic [DATA_WIDTH-1:0] wr_data_hi,
    input  logic                  rd_bank,
    input  logic [IDX_WIDTH-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data_c
);

    logic [DATA_WIDTH-1:0] mem [2][RING_SIZE];

    // Index k+N/2 is k with the top address bit set, since N is a power of two.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][{1'b0, wr_addr}] <= wr_data_lo;
            mem[wr_bank][{1'b1, wr_addr}] <= wr_data_hi;
        end
    end

    assign rd_data_c = mem[rd_bank][rd_addr];

endmodule

// File: rtl/ntt_output_collector.sv
// NTT unload stage: captures final-stage butterfly pairs into a ping-pong buffer and
// streams each finished polynomial out in natural order over valid/ready.
module ntt_output_collector
    import ntt_pkg::*;
#(
    parameter int unsigned RING_SIZE  = NTT_RING_SIZE,
    parameter int unsigned DATA_WIDTH = NTT_DATA_WIDTH,
    parameter int unsigned IDX_WIDTH  = $clog2(RING_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  in_last_stage,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [IDX_WIDTH-1:0]  out_index,
    output logic                  out_last,
    output logic                  busy,
    output logic                  overflow
);

    localparam int unsigned         KW       = IDX_WIDTH - 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(RING_SIZE - 1);
    localparam logic [KW-1:0]        K_LAST   = KW'(RING_SIZE / 2 - 1);

    rd_state_e             state_q, state_d;
    logic [KW-1:0]         k_q, k_d;
    logic                  wbank_q, wbank_d;
    logic                  rbank_q, rbank_d;
    logic [1:0]            full_q, full_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [IDX_WIDTH-1:0]  out_index_q, out_index_d;
    logic                  out_last_q, out_last_d;
    logic                  busy_q, busy_d;
    logic                  overflow_q, overflow_d;

    logic                  pair_c, wr_en_c, xfer_c, final_xfer_c;
    logic [IDX_WIDTH-1:0]  rd_addr_c;
    logic [DATA_WIDTH-1:0] rd_data_c;

    assign pair_c       = in_valid && in_last_stage;
    assign wr_en_c      = pair_c && !full_q[wbank_q];
    assign xfer_c       = out_valid_q && out_ready;
    assign final_xfer_c = xfer_c && (out_index_q == LAST_IDX);
    // IDLE always prefetches word 0; STREAM prefetches the word after the one on the bus.
    assign rd_addr_c    = (state_q == RD_STREAM) ? out_index_q + IDX_WIDTH'(1) : '0;

    ntt_pingpong_bank #(
        .RING_SIZE (RING_SIZE),
        .DATA_WIDTH(DATA_WIDTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_bank (
        .clk       (clk),
        .wr_en     (wr_en_c),
        .wr_bank   (wbank_q),
        .wr_addr   (k_q),
        .wr_data_lo(in_a),
        .wr_data_hi(in_b),
        .rd_bank   (rbank_q),
        .rd_addr   (rd_addr_c),
        .rd_data_c (rd_data_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RD_IDLE;
            k_q         <= '0;
            wbank_q     <= 1'b0;
            rbank_q     <= 1'b0;
            full_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            wbank_q     <= wbank_d;
            rbank_q     <= rbank_d;
            full_q      <= full_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RD_IDLE:   if (full_q[rbank_q]) state_d = RD_STREAM;
            RD_STREAM: if (final_xfer_c)    state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        k_d         = k_q;
        wbank_d     = wbank_q;
        rbank_d     = rbank_q;
        full_d      = full_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        overflow_d  = overflow_q;

        // Writer: the full flag it sees is last cycle's, so a bank freed this edge stays closed.
        if (wr_en_c) begin
            k_d = k_q + KW'(1);
            if (k_q == K_LAST) begin
                full_d[wbank_q] = 1'b1;
                wbank_d         = ~wbank_q;
            end
        end
        if (pair_c && full_q[wbank_q]) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            RD_IDLE: begin
                if (full_q[rbank_q]) begin
                    out_valid_d = 1'b1;
                    out_index_d = '0;
                    out_data_d  = rd_data_c;
                end
            end
            RD_STREAM: begin
                if (final_xfer_c) begin
                    full_d[rbank_q] = 1'b0;
                    rbank_d         = ~rbank_q;
                    out_valid_d     = 1'b0;
                    out_index_d     = '0;
                end else if (xfer_c) begin
                    out_index_d = rd_addr_c;
                    out_data_d  = rd_data_c;
                end
            end
        endcase

        out_last_d = out_valid_d && (out_index_d == LAST_IDX);
        busy_d     = (|full_d) || (k_d != '0);
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_ntt_output_collector.sv
// Scoreboard bench for ntt_output_collector at N=8: directed polynomials, stalls, overflow, reset.
module tb_ntt_output_collector;

    localparam int unsigned N  = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 3;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [IW-1:0] idx;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_last_stage;
    logic [DW-1:0] in_a, in_b;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_index;
    logic          out_last, busy, overflow;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   xfer_cnt = 0;
    exp_t exp_q[$];

    logic       ready_lvl = 1'b0;
    logic       pat_en    = 1'b0;
    logic [3:0] ready_pat = 4'b1001;
    int         pat_ph    = 0;

    ntt_output_collector #(.RING_SIZE(N), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_last_stage(in_last_stage),
        .in_a         (in_a),
        .in_b         (in_b),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_index    (out_index),
        .out_last     (out_last),
        .busy         (busy),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // Consumer ready: either a fixed level or the repeating 1,0,0,1 pattern.
    always @(posedge clk) begin
        #2;
        out_ready = pat_en ? ready_pat[pat_ph] : ready_lvl;
        pat_ph    = (pat_ph == 3) ? 0 : pat_ph + 1;
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per transfer and checks hold-stability across stalls.
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic [IW-1:0] prev_idx;
    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_index !== prev_idx) begin
                    n_fail++;
                    $display("FAIL stall_hold: got v=%0b d=%0h i=%0d expected v=1 d=%0h i=%0d",
                             out_valid, out_data, out_index, prev_data, prev_idx);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                xfer_cnt++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out: got d=%0h i=%0d expected no transfer",
                             out_data, out_index);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (out_data !== e.data || out_index !== e.idx || out_last !== e.last) begin
                        n_fail++;
                        $display("FAIL stream: got d=%0h i=%0d l=%0b expected d=%0h i=%0d l=%0b",
                                 out_data, out_index, out_last, e.data, e.idx, e.last);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_idx   = out_index;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected stream for pairs a=a0+k, b=b0+k: indices 0..N/2-1 carry a, the rest carry b.
    task automatic push_exp(input logic [DW-1:0] a0, input logic [DW-1:0] b0, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            exp_t e;
            e.data = (i < N/2) ? a0 + DW'(i) : b0 + DW'(i - N/2);
            e.idx  = IW'(i);
            e.last = (i == N - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_poly(input logic [DW-1:0] a0, input logic [DW-1:0] b0);
        for (int k = 0; k < N/2; k++) begin
            in_valid = 1'b1; in_last_stage = 1'b1;
            in_a = a0 + DW'(k); in_b = b0 + DW'(k);
            tick();
        end
    endtask

    task automatic idle_in();
        in_valid = 1'b0; in_last_stage = 1'b0; in_a = '0; in_b = '0;
    endtask

    task automatic wait_drain();
        int c = 0;
        while (exp_q.size() != 0 && c < 300) begin
            tick();
            c++;
        end
        chk("drain_left", DW'(exp_q.size()), '0);
        tick();
    endtask

    initial begin
        int x0;
        reset = 1'b0;
        idle_in();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", DW'(out_valid), '0);
        chk("rst_data", out_data, '0);
        chk("rst_index", DW'(out_index), '0);
        chk("rst_last", DW'(out_last), '0);
        chk("rst_busy", DW'(busy), '0);
        chk("rst_ovf", DW'(overflow), '0);
        reset = 1'b1;
        tick();

        // Basic polynomial, consumer always ready.
        ready_lvl = 1'b1;
        push_exp(32'h1, 32'h11, N);
        send_poly(32'h1, 32'h11);
        idle_in();
        chk("lat_valid_e", DW'(out_valid), '0);
        chk("lat_busy_e", DW'(busy), 32'h1);
        tick();
        chk("lat_valid_e1", DW'(out_valid), 32'h1);
        chk("lat_index_e1", DW'(out_index), '0);
        chk("lat_data_e1", out_data, 32'h1);
        wait_drain();
        chk("t1_busy_end", DW'(busy), '0);

        // Same polynomial with a stalling consumer.
        x0 = xfer_cnt;
        pat_en = 1'b1;
        push_exp(32'h1, 32'h11, N);
        send_poly(32'h1, 32'h11);
        idle_in();
        wait_drain();
        chk("t2_xfers", DW'(xfer_cnt - x0), DW'(N));
        pat_en = 1'b0;

        // Non-final-stage pairs are ignored.
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_last_stage = 1'b0;
            in_a = $urandom; in_b = $urandom;
            tick();
            chk("t3_busy", DW'(busy), '0);
            chk("t3_valid", DW'(out_valid), '0);
        end
        idle_in();

        // Both banks full, ninth pair dropped, then drain with one bubble.
        ready_lvl = 1'b0;
        tick();
        push_exp(32'h100, 32'h200, N);
        push_exp(32'h300, 32'h400, N);
        send_poly(32'h100, 32'h200);
        send_poly(32'h300, 32'h400);
        chk("t4_ovf_pre", DW'(overflow), '0);
        in_valid = 1'b1; in_last_stage = 1'b1; in_a = 32'hDEAD; in_b = 32'hBEEF;
        tick();
        idle_in();
        chk("t4_ovf", DW'(overflow), 32'h1);
        chk("t4_busy", DW'(busy), 32'h1);
        chk("t4_stall_idx", DW'(out_index), '0);
        ready_lvl = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("t4_bubble%0d", i), DW'(out_valid),
                (i == 8 || i >= 17) ? '0 : 32'h1);
            tick();
        end
        wait_drain();
        chk("t4_ovf_sticky", DW'(overflow), 32'h1);
        chk("t4_busy_end", DW'(busy), '0);

        // Asynchronous reset while index 3 is on the bus.
        push_exp(32'h500, 32'h600, 3);
        send_poly(32'h500, 32'h600);
        idle_in();
        begin
            int c = 0;
            while (!(out_valid === 1'b1 && out_index === 3'd3) && c < 50) begin
                tick();
                c++;
            end
            chk("t5_reach_idx3", DW'(c < 50), 32'h1);
        end
        #2;
        reset = 1'b0;
        #1;
        chk("t5_valid", DW'(out_valid), '0);
        chk("t5_data", out_data, '0);
        chk("t5_index", DW'(out_index), '0);
        chk("t5_last", DW'(out_last), '0);
        chk("t5_busy", DW'(busy), '0);
        chk("t5_ovf", DW'(overflow), '0);
        chk("t5_q_empty", DW'(exp_q.size()), '0);
        tick();
        tick();
        reset = 1'b1;
        chk("t5_ovf_after", DW'(overflow), '0);

        // Fresh polynomial; the next one completes on the edge bank 0 is freed.
        push_exp(32'h700, 32'h800, N);
        push_exp(32'h900, 32'hA00, N);
        send_poly(32'h700, 32'h800);
        idle_in();
        tick();
        chk("t6_first_valid", DW'(out_valid), 32'h1);
        chk("t6_first_idx", DW'(out_index), '0);
        chk("t6_first_data", out_data, 32'h700);
        repeat (4) tick();
        for (int k = 0; k < N/2; k++) begin
            in_valid = 1'b1; in_last_stage = 1'b1;
            in_a = 32'h900 + DW'(k); in_b = 32'hA00 + DW'(k);
            if (k == N/2 - 1) begin
                chk("t6_sync_idx7", DW'(out_index), DW'(N - 1));
                chk("t6_sync_last", DW'(out_last), 32'h1);
            end
            tick();
        end
        idle_in();
        chk("t6_bubble", DW'(out_valid), '0);
        chk("t6_busy", DW'(busy), 32'h1);
        tick();
        chk("t6_b_valid", DW'(out_valid), 32'h1);
        chk("t6_b_idx", DW'(out_index), '0);
        chk("t6_b_data", out_data, 32'h900);
        wait_drain();
        chk("t6_ovf", DW'(overflow), '0);
        chk("t6_busy_end", DW'(busy), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
